// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions used by the instruction encoder (and by the decoder
// that consumes the same one-hot class vector).
//   - major opcode constants
//   - one-hot class bit indices
//   - encoder error codes and the canonical NOP
//   - encoder FSM state type
//   - small range/one-hot helper functions
// -----------------------------------------------------------------------------
package rv32i_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // One-hot instruction class vector layout
    localparam int CLS_W      = 9;
    localparam int CLS_LUI    = 0;
    localparam int CLS_AUIPC  = 1;
    localparam int CLS_JALR   = 2;
    localparam int CLS_JAL    = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_STORE  = 5;
    localparam int CLS_LOAD   = 6;
    localparam int CLS_OP_IMM = 7;
    localparam int CLS_OP     = 8;

    // Legality error codes; a lower code has higher priority
    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_CLASS  = 3'd1,
        ERR_FUNCT3 = 3'd2,
        ERR_ALT    = 3'd3,
        ERR_IMM    = 3'd4,
        ERR_ALIGN  = 3'd5
    } err_code_e;

    // ADDI x0, x0, 0 -- written in place of any illegal request
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    // True when value is the sign extension of its low 'width' bits.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned width);
        logic [31:0] upper;
        upper = $signed(value) >>> (width - 1);
        return (upper == '0) || (upper == '1);
    endfunction

    function automatic logic is_one_hot(input logic [CLS_W-1:0] cls);
        return (cls != '0) && ((cls & (cls - 9'd1)) == '0);
    endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// -----------------------------------------------------------------------------
// rv32i_instr_encoder_if
// Request stream into the encoder plus the instruction-memory write stream out
// of it. Both are valid/ready channels.
//   slave  : encoder side (consumes requests, produces writes)
//   master : program source / memory side
// Signals:
//   in_valid/in_ready, in_cls[8:0], in_funct3, in_alt, in_rd, in_rs1, in_rs2,
//   in_imm[31:0]; out_valid/out_ready, out_addr[ADDR_W-1:0], out_instr[31:0]
// -----------------------------------------------------------------------------
interface rv32i_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    import rv32i_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CLS_W-1:0]  in_cls;
    logic [2:0]        in_funct3;
    logic              in_alt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_instr;

    modport master (
        output in_valid, in_cls, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_addr, out_instr
    );

    modport slave (
        input  in_valid, in_cls, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_addr, out_instr
    );

endinterface

// File: rtl/rv32i_field_pack.sv
// -----------------------------------------------------------------------------
// rv32i_field_pack
// Purely combinational: packs one instruction request into an RV32I word and
// reports the highest-priority legality error. Illegal requests produce NOP.
// Ports:
//   cls[8:0]    one-hot instruction class
//   funct3      funct3 field
//   alt         instr[30] select (SUB/SRA/SRAI)
//   rd/rs1/rs2  register indices
//   imm[31:0]   full signed immediate
//   word[31:0]  encoded instruction (NOP when err_code != ERR_NONE)
//   err_code    first failing check, ERR_NONE when legal
// -----------------------------------------------------------------------------
module rv32i_field_pack
    import rv32i_pkg::*;
(
    input  logic [CLS_W-1:0] cls,
    input  logic [2:0]       funct3,
    input  logic             alt,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic [31:0]      word,
    output err_code_e        err_code
);

    logic        is_shift;
    logic        is_i_imm;
    logic        bad_cls;
    logic        bad_funct3;
    logic        bad_alt;
    logic        bad_imm;
    logic        bad_align;
    logic [31:0] raw;

    // SLLI/SRLI/SRAI carry a shamt instead of a 12-bit immediate.
    assign is_shift = cls[CLS_OP_IMM] && (funct3 == 3'b001 || funct3 == 3'b101);
    assign is_i_imm = cls[CLS_LOAD] || cls[CLS_JALR] || (cls[CLS_OP_IMM] && !is_shift);

    assign bad_cls = !is_one_hot(cls);

    assign bad_funct3 = (cls[CLS_BRANCH] && (funct3 == 3'b010 || funct3 == 3'b011))
                     || (cls[CLS_LOAD]   && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                     || (cls[CLS_STORE]  && (funct3 >= 3'b011))
                     || (cls[CLS_JALR]   && (funct3 != 3'b000));

    assign bad_alt = (cls[CLS_OP]     && alt && !(funct3 == 3'b000 || funct3 == 3'b101))
                  || (cls[CLS_OP_IMM] && alt && (funct3 != 3'b101))
                  || (is_shift && (imm[31:5] != '0));

    assign bad_imm = ((is_i_imm || cls[CLS_STORE]) && !fits_signed(imm, 12))
                  || (cls[CLS_BRANCH] && !fits_signed(imm, 13))
                  || (cls[CLS_JAL]    && !fits_signed(imm, 21))
                  || ((cls[CLS_LUI] || cls[CLS_AUIPC]) && (imm[11:0] != '0));

    assign bad_align = (cls[CLS_BRANCH] || cls[CLS_JAL]) && imm[0];

    // Raw field packing; only meaningful when cls is one-hot.
    always_comb begin
        // NOTE: default first so every path assigns raw and no latch is inferred.
        raw = INSTR_NOP;
        if (cls[CLS_OP]) begin
            raw = {1'b0, alt, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
        end else if (cls[CLS_OP_IMM]) begin
            if (is_shift) begin
                raw = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
            end else begin
                raw = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
            end
        end else if (cls[CLS_LOAD]) begin
            raw = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        end else if (cls[CLS_STORE]) begin
            raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        end else if (cls[CLS_BRANCH]) begin
            raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        end else if (cls[CLS_JAL]) begin
            raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        end else if (cls[CLS_JALR]) begin
            raw = {imm[11:0], rs1, funct3, rd, OPC_JALR};
        end else if (cls[CLS_AUIPC]) begin
            raw = {imm[31:12], rd, OPC_AUIPC};
        end else if (cls[CLS_LUI]) begin
            raw = {imm[31:12], rd, OPC_LUI};
        end
    end

    // Priority: the lowest failing code is reported.
    always_comb begin
        err_code = ERR_NONE;
        word     = raw;
        if (bad_cls) begin
            err_code = ERR_CLASS;
        end else if (bad_funct3) begin
            err_code = ERR_FUNCT3;
        end else if (bad_alt) begin
            err_code = ERR_ALT;
        end else if (bad_imm) begin
            err_code = ERR_IMM;
        end else if (bad_align) begin
            err_code = ERR_ALIGN;
        end
        if (err_code != ERR_NONE) begin
            word = INSTR_NOP;
        end
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// -----------------------------------------------------------------------------
// rv32i_instr_encoder
// Streams a program of word_count encoded RV32I words to instruction memory,
// starting at base_addr. One request in, one word out, through a single-entry
// output register that can reload in the same cycle it drains.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle load pulse (honoured only in IDLE)
//   base_addr           first write address (low two bits dropped)
//   word_count          number of requests in the load
//   bus                 request and write channels (slave modport)
//   busy                load in progress
//   done                one-cycle pulse when the load completes
//   err                 sticky error flag, cleared on start
//   err_code/err_index  code and 0-based request index of the first error
// -----------------------------------------------------------------------------
module rv32i_instr_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_count,
    rv32i_instr_encoder_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          err_code,
    output logic [CNT_W-1:0]    err_index
);

    enc_state_e        state_q;
    enc_state_e        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  idx_q;
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [31:0]       out_instr_q;
    logic              err_q;
    err_code_e         err_code_q;
    logic [CNT_W-1:0]  err_index_q;

    logic              in_ready;
    logic              accept;
    logic [31:0]       pack_word;
    err_code_e         pack_err;

    rv32i_field_pack u_field_pack (
        .cls      (bus.in_cls),
        .funct3   (bus.in_funct3),
        .alt      (bus.in_alt),
        .rd       (bus.in_rd),
        .rs1      (bus.in_rs1),
        .rs2      (bus.in_rs2),
        .imm      (bus.in_imm),
        .word     (pack_word),
        .err_code (pack_err)
    );

    // The output register can take a new word whenever it is empty or is
    // being drained this cycle, so a full stream runs without bubbles.
    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_instr = out_instr_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign err_index     = err_index_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (word_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (remaining_q == CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q || bus.out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            addr_q      <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_instr_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                addr_q      <= base_addr & ~ADDR_W'(3);
                remaining_q <= word_count;
                idx_q       <= '0;
                err_q       <= 1'b0;
                err_code_q  <= ERR_NONE;
                err_index_q <= '0;
            end

            if (accept) begin
                addr_q      <= addr_q + ADDR_W'(4);
                remaining_q <= remaining_q - CNT_W'(1);
                idx_q       <= idx_q + CNT_W'(1);
                out_valid_q <= 1'b1;
                out_addr_q  <= addr_q;
                out_instr_q <= pack_word;
                if (pack_err != ERR_NONE) begin
                    err_q <= 1'b1;
                    // Only the first error of a load is recorded.
                    if (!err_q) begin
                        err_code_q  <= pack_err;
                        err_index_q <= idx_q;
                    end
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_rv32i_instr_encoder
// Directed bench for rv32i_instr_encoder. Expected writes are queued when a
// request is driven and compared in order as the memory handshake completes.
// -----------------------------------------------------------------------------
module tb_rv32i_instr_encoder;
    import rv32i_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [8:0] C_NONE   = 9'h000;
    localparam logic [8:0] C_LUI    = 9'h001;
    localparam logic [8:0] C_JALR   = 9'h004;
    localparam logic [8:0] C_JAL    = 9'h008;
    localparam logic [8:0] C_BRANCH = 9'h010;
    localparam logic [8:0] C_STORE  = 9'h020;
    localparam logic [8:0] C_LOAD   = 9'h040;
    localparam logic [8:0] C_OP_IMM = 9'h080;
    localparam logic [8:0] C_OP     = 9'h100;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        err_code;
    logic [CNT_W-1:0]  err_index;

    rv32i_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    rv32i_instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .err_index  (err_index)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } wr_t;

    wr_t         sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_addr = '0;
    int          waits;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-side monitor: every completed write must match the queue head.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write_addr", bus.out_addr, e.addr);
                check("write_instr", bus.out_instr, e.instr);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_addr = base & ~32'd3;
    endtask

    task automatic set_req(input logic [8:0] cls, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic [31:0] exp_instr);
        bus.in_valid  = 1'b1;
        bus.in_cls    = cls;
        bus.in_funct3 = f3;
        bus.in_alt    = alt;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        sb.push_back({exp_addr, exp_instr});
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic wait_accept(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        check("accept_in_time", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [8:0] cls, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] exp_instr, output int n);
        set_req(cls, f3, alt, rd, rs1, rs2, imm, exp_instr);
        wait_accept(n);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        check("sb_drained_at_done", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin : stimulus
        bus.in_valid  = 1'b0;
        bus.in_cls    = '0;
        bus.in_funct3 = '0;
        bus.in_alt    = 1'b0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_addr", bus.out_addr, 64'd0);
        check("rst_out_instr", bus.out_instr, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_err_index", 64'(err_index), 64'd0);
        #10 rst_n = 1'b1;

        // Single ADDI
        do_start(32'h100, 16'd1);
        check("busy_after_start", 64'(busy), 64'd1);
        send(C_OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, waits);
        wait_done();

        // Three-word stream with no bubbles
        do_start(32'h200, 16'd3);
        send(C_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, waits);
        check("stream_wait0", waits, 64'd1);
        send(C_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, waits);
        check("stream_wait1", waits, 64'd1);
        send(C_OP, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, waits);
        check("stream_wait2", waits, 64'd1);
        wait_done();

        // SRAI, then misaligned JAL, then an empty class
        do_start(32'h300, 16'd3);
        send(C_OP_IMM, 3'b101, 1'b1, 5'd5, 5'd5, 5'd0, 32'd3, 32'h4032_D293, waits);
        check("no_err_srai", 64'(err), 64'd0);
        send(C_JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3, NOP, waits);
        check("jal_err", 64'(err), 64'd1);
        check("jal_err_code", 64'(err_code), 64'd5);
        check("jal_err_index", 64'(err_index), 64'd1);
        send(C_NONE, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, NOP, waits);
        wait_done();
        check("sticky_err", 64'(err), 64'd1);
        check("sticky_err_code", 64'(err_code), 64'd5);
        check("sticky_err_index", 64'(err_index), 64'd1);

        // Start clears err; bad load funct3 first, then immediate range edges
        do_start(32'h380, 16'd3);
        check("err_cleared", 64'(err), 64'd0);
        check("err_code_cleared", 64'(err_code), 64'd0);
        send(C_LOAD, 3'b110, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, NOP, waits);
        check("load_f3_code", 64'(err_code), 64'd2);
        check("load_f3_index", 64'(err_index), 64'd0);
        send(C_OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, NOP, waits);
        send(C_OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, waits);
        wait_done();
        check("first_err_kept", 64'(err_code), 64'd2);

        // Backpressure
        do_start(32'h400, 16'd3);
        bus.out_ready = 1'b0;
        send(C_OP, 3'b000, 1'b0, 5'd4, 5'd2, 5'd3, 32'd0, 32'h0031_0233, waits);
        set_req(C_OP, 3'b101, 1'b1, 5'd6, 5'd7, 5'd8, 32'd0, 32'h4083_D333);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_addr", bus.out_addr, 64'h400);
            check("bp_out_instr", bus.out_instr, 64'h0031_0233);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_accept(waits);
        check("bp_release_wait", waits, 64'd1);
        send(C_JALR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 32'hFF81_00E7, waits);
        check("bp_b2b_wait", waits, 64'd1);
        wait_done();

        // Zero-length load
        do_start(32'h500, 16'd0);
        wait_done();

        // Start while RUN is ignored
        do_start(32'h600, 16'd2);
        send(C_OP_IMM, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, waits);
        check("busy_in_run", 64'(busy), 64'd1);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = 32'h700;
        word_count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        send(C_LUI, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_50B7, waits);
        wait_done();

        // Reset mid-load: two writes complete, third is held then aborted
        do_start(32'h800, 16'd4);
        send(C_OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, waits);
        send(C_OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2, 32'h0020_0093, waits);
        @(negedge clk);
        @(posedge clk); #1;
        check("two_writes_done", 64'(sb.size()), 64'd0);
        bus.out_ready = 1'b0;
        send(C_OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 32'h0030_0093, waits);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_out_addr", bus.out_addr, 64'd0);
        check("arst_out_instr", bus.out_instr, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd0);
        sb.delete();
        set_req(C_OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4, 32'h0040_0093);
        sb.delete();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_in_ready", 64'(bus.in_ready), 64'd0);
            check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end
        bus.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Inverse of the control-unit decode path. Takes structured instruction requests and emits legal RV32I instruction words. Each request carries a one-hot class (same 9-bit class vector the decoder consumes), funct3, alt bit, register fields and a 32-bit immediate. Sits between the test/boot program source and the instruction-memory write port, and streams a program of word_count words starting at base_addr.

Parameters:
ADDR_W, 32, instruction-memory byte-address width
CNT_W, 16, width of word counter and word_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse, begins a load; ignored unless IDLE
base_addr  in  ADDR_W  first write address, sampled on start (must be 4-aligned; bits[1:0] forced 0)
word_count  in  CNT_W  number of requests in this load, sampled on start
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_cls  in  9  one-hot class: [8]OP [7]OP-IMM [6]LOAD [5]STORE [4]BRANCH [3]JAL [2]JALR [1]AUIPC [0]LUI
in_funct3  in  3  funct3
in_alt  in  1  instr[30] select (SUB/SRA/SRAI)
in_rd, in_rs1, in_rs2  in  5 each  register indices
in_imm  in  32  immediate, full signed value
out_valid  out  1  write valid
out_ready  in  1  memory accepts
out_addr  out  ADDR_W  byte address
out_instr  out  32  encoded word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at load completion
err  out  1  sticky; cleared on start
err_code  out  3  code of first error in the current load
err_index  out  CNT_W  request index (0-based) of first error

Behaviour:
- Reset: state IDLE. in_ready, out_valid, busy, done and err are 0. out_addr, out_instr, err_code and err_index are 0. Counters are 0. A reset asserted mid-load aborts the load with no further writes.
- FSM:
  - IDLE: on start, latch addr=base_addr, remaining=word_count, idx=0, clear err/err_code/err_index. Go to RUN, or to DONE if word_count==0.
  - RUN: each accept decrements remaining. The accept that takes remaining to 0 moves to DRAIN.
  - DRAIN: move to DONE once out_valid==0 or the final out handshake completes in that cycle.
  - DONE: done=1 for one cycle, then IDLE.
- Output register is a single-entry pipeline stage:
  - in_ready = (state==RUN) & (!out_valid | out_ready).
  - Accept to out_valid latency is 1 cycle.
  - out_addr/out_instr hold stable while out_valid & !out_ready.
  - addr += 4 on every accept. Wrap-around at 2^ADDR_W is modulo.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Field packing:
  - I: imm[11:0]→[31:20]
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7]
  - B: imm[12],imm[10:5]→[31:25]; imm[4:1],imm[11]→[11:7]
  - U: imm[31:12]→[31:12]
  - J: imm[20],imm[10:1],imm[11],imm[19:12]→[31:12]
  - OP: [31:25]={0,alt,00000}
  - OP-IMM shifts (f3 001/101): [31:25]={0,alt,00000}, [24:20]=imm[4:0]
- Legality checks, in priority order (lowest code wins):
  - 1: in_cls not exactly one-hot
  - 2: bad funct3. Branch 010/011; load 011/110/111; store ≥011; JALR ≠000.
  - 3: bad alt. OP alt=1 with f3∉{000,101}; OP-IMM alt=1 with f3≠101; shift with imm[31:5]≠0.
  - 4: immediate out of range. I/S not 12-bit sign-extended; B not 13-bit; J not 21-bit; U imm[11:0]≠0.
  - 5: misaligned. B/J imm[0]=1.
- On an illegal request: the slot is still consumed, and 0x00000013 (ADDI x0,x0,0) is written at that address. err is set. err_code/err_index are latched only if err was 0.
- Simultaneous out handshake and new accept in the same cycle: the register reloads with no bubble.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants
  - class bit indices (shared with the decoder)
  - error-code constants
  - NOP constant
- One combinational sub-module, rv32i_field_pack: takes class, fields and imm; returns word and err_code. The top level holds the FSM, counters and output register.

Test Plan:
- start base=0x100, count=1; OP-IMM f3=000 rd=1 rs1=0 imm=5 → one write addr 0x100 instr 0x00500093, then done pulse, busy=0.
- count=3 stream, out_ready=1:
  - STORE f3=010 rs1=1 rs2=2 imm=8 → 0x0020A423
  - BRANCH f3=000 rs1=1 rs2=2 imm=-4 → 0xFE208EE3
  - OP f3=000 alt=1 rd=3 rs1=1 rs2=2 → 0x402081B3
  - Required: addresses +4 each, no bubbles.
- OP-IMM f3=101 alt=1 rd=5 rs1=5 imm=3 → 0x4032D293. Then JAL imm=3 → writes 0x00000013, err=1, err_code=5, err_index=1. A later in_cls=0 leaves err_code at 5.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → out_valid/out_addr/out_instr stable, in_ready=0. Releasing out_ready gives back-to-back writes, with no loss or duplication.
- count=0 start → done pulse 2 cycles later, no writes. A start pulse while RUN is ignored.
- Assert rst_n low mid-load (after 2 of 4 writes) → all outputs 0 asynchronously, IDLE, no further writes after release.
